// File: rtl/round_controller.sv
// Two-player round controller: health, lives, respawn timing and winner for the HUD.
// Optional `INVULN_EN adds a post-hit / post-spawn immunity state timed in frame ticks.
module round_controller #(
  parameter int MAX_HEALTH     = 5,
  parameter int MAX_LIVES      = 3,
  parameter int RESPAWN_FRAMES = 60,
  parameter int INVULN_FRAMES  = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       hit1,
  input  logic       hit2,
  input  logic       fall1,
  input  logic       fall2,
  input  logic       restart,
  output logic [9:0] Player1Health,
  output logic [9:0] Player2Health,
  output logic [9:0] Player1Lives,
  output logic [9:0] Player2Lives,
  output logic [1:0] winner,
  output logic       respawn1,
  output logic       respawn2,
  output logic       alive1,
  output logic       alive2
);

  localparam int HW = $clog2(MAX_HEALTH + 1);
  localparam int LW = $clog2(MAX_LIVES + 1);
  localparam logic [HW-1:0] HEALTH_FULL = HW'(MAX_HEALTH);
  localparam logic [LW-1:0] LIVES_FULL  = LW'(MAX_LIVES);
  localparam logic [7:0]    RESP_CNT    = 8'(RESPAWN_FRAMES);

  if (MAX_HEALTH < 1 || MAX_HEALTH > 14) begin : g_bad_health
    $error("MAX_HEALTH must be 1..14");
  end
  if (RESPAWN_FRAMES > 255 || INVULN_FRAMES > 255) begin : g_bad_frames
    $error("frame counts must fit in 8 bits");
  end

`ifdef INVULN_EN
  localparam logic [7:0] INV_CNT = 8'(INVULN_FRAMES);
  typedef enum logic [1:0] {ALIVE, INVULN, DEAD, OUT} pstate_t;
`else
  typedef enum logic [1:0] {ALIVE, DEAD, OUT} pstate_t;
`endif
  typedef enum logic {PLAY, OVER} gstate_t;

  gstate_t         gst, gst_n;
  logic [1:0]      winner_r, winner_n;
  pstate_t         pst       [2];
  pstate_t         pst_n     [2];
  logic [HW-1:0]   health    [2];
  logic [HW-1:0]   health_n  [2];
  logic [LW-1:0]   lives     [2];
  logic [LW-1:0]   lives_n   [2];
  logic [7:0]      cnt       [2];
  logic [7:0]      cnt_n     [2];
  logic            alive     [2];
  logic            alive_n   [2];
  logic            respawn   [2];
  logic            respawn_n [2];
  logic            kill      [2];
  logic            enter_out [2];
  logic            hit       [2];
  logic            fall      [2];

  assign hit[0]  = hit1;
  assign hit[1]  = hit2;
  assign fall[0] = fall1;
  assign fall[1] = fall2;

  always_comb begin
    gst_n    = gst;
    winner_n = winner_r;
    for (int p = 0; p < 2; p++) begin
      pst_n[p]     = pst[p];
      health_n[p]  = health[p];
      lives_n[p]   = lives[p];
      cnt_n[p]     = cnt[p];
      alive_n[p]   = alive[p];
      respawn_n[p] = 1'b0;
      kill[p]      = 1'b0;
      enter_out[p] = 1'b0;
      if (gst == OVER) begin
        if (restart) begin
          pst_n[p]     = ALIVE;
          health_n[p]  = HEALTH_FULL;
          lives_n[p]   = LIVES_FULL;
          cnt_n[p]     = 8'd0;
          alive_n[p]   = 1'b1;
          respawn_n[p] = 1'b1;
        end
      end else begin
        case (pst[p])
          ALIVE: begin
            // fall outranks a coincident hit, so a death is only ever counted once
            if (fall[p] || (hit[p] && health[p] <= HW'(1))) begin
              kill[p] = 1'b1;
            end else if (hit[p]) begin
              health_n[p] = health[p] - 1'b1;
`ifdef INVULN_EN
              pst_n[p] = INVULN;
              cnt_n[p] = INV_CNT;
`endif
            end
          end
`ifdef INVULN_EN
          INVULN: begin
            if (fall[p]) begin
              kill[p] = 1'b1;
            end else if (frame_tick) begin
              if (cnt[p] <= 8'd1) begin
                pst_n[p] = ALIVE;
                cnt_n[p] = 8'd0;
              end else begin
                cnt_n[p] = cnt[p] - 8'd1;
              end
            end
          end
`endif
          DEAD: begin
            if (frame_tick) begin
              if (cnt[p] <= 8'd1) begin
                health_n[p]  = HEALTH_FULL;
                alive_n[p]   = 1'b1;
                respawn_n[p] = 1'b1;
`ifdef INVULN_EN
                pst_n[p] = INVULN;
                cnt_n[p] = INV_CNT;
`else
                pst_n[p] = ALIVE;
                cnt_n[p] = 8'd0;
`endif
              end else begin
                cnt_n[p] = cnt[p] - 8'd1;
              end
            end
          end
          default: ;
        endcase
        if (kill[p]) begin
          health_n[p] = '0;
          lives_n[p]  = (lives[p] == '0) ? '0 : lives[p] - 1'b1;
          alive_n[p]  = 1'b0;
          if (lives[p] <= LW'(1)) begin
            pst_n[p]     = OUT;
            cnt_n[p]     = 8'd0;
            enter_out[p] = 1'b1;
          end else begin
            pst_n[p] = DEAD;
            cnt_n[p] = RESP_CNT;
          end
        end
      end
    end
    if (gst == OVER && restart) begin
      gst_n    = PLAY;
      winner_n = 2'd0;
    end else if (gst == PLAY && (enter_out[0] || enter_out[1])) begin
      gst_n = OVER;
      if (enter_out[0] && enter_out[1]) winner_n = 2'd3;
      else if (enter_out[0])            winner_n = 2'd2;
      else                              winner_n = 2'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      gst      <= PLAY;
      winner_r <= 2'd0;
      for (int p = 0; p < 2; p++) begin
        pst[p]     <= ALIVE;
        health[p]  <= HEALTH_FULL;
        lives[p]   <= LIVES_FULL;
        cnt[p]     <= 8'd0;
        alive[p]   <= 1'b1;
        respawn[p] <= 1'b0;
      end
    end else begin
      gst      <= gst_n;
      winner_r <= winner_n;
      for (int p = 0; p < 2; p++) begin
        pst[p]     <= pst_n[p];
        health[p]  <= health_n[p];
        lives[p]   <= lives_n[p];
        cnt[p]     <= cnt_n[p];
        alive[p]   <= alive_n[p];
        respawn[p] <= respawn_n[p];
      end
    end
  end

  assign Player1Health = 10'(health[0]);
  assign Player2Health = 10'(health[1]);
  assign Player1Lives  = 10'(lives[0]);
  assign Player2Lives  = 10'(lives[1]);
  assign winner        = winner_r;
  assign respawn1      = respawn[0];
  assign respawn2      = respawn[1];
  assign alive1        = alive[0];
  assign alive2        = alive[1];

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: vector table, hand-written round scenarios, and
// randomized events checked against an integer-level model of the round rules.
module tb_round_controller;
  localparam int MAXH = 5, MAXL = 3, RESP = 60, INV = 30;
`ifdef INVULN_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic Clk = 1'b0, Reset = 1'b1, frame_tick = 1'b0, restart = 1'b0;
  logic hit1 = 1'b0, hit2 = 1'b0, fall1 = 1'b0, fall2 = 1'b0;
  logic [9:0] Player1Health, Player2Health, Player1Lives, Player2Lives;
  logic [1:0] winner;
  logic respawn1, respawn2, alive1, alive2;

  round_controller #(.MAX_HEALTH(MAXH), .MAX_LIVES(MAXL),
                     .RESPAWN_FRAMES(RESP), .INVULN_FRAMES(INV)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
    .hit1(hit1), .hit2(hit2), .fall1(fall1), .fall2(fall2), .restart(restart),
    .Player1Health(Player1Health), .Player2Health(Player2Health),
    .Player1Lives(Player1Lives), .Player2Lives(Player2Lives),
    .winner(winner), .respawn1(respawn1), .respawn2(respawn2),
    .alive1(alive1), .alive2(alive2));

  always #5 Clk = ~Clk;

  int n_chk = 0, n_pass = 0;

  // model: health, lives, respawn countdown (0 = not waiting), immunity frames left
  int m_h[2], m_l[2], m_dead[2], m_inv[2], m_win;
  bit m_over, m_resp[2], m_alive[2];

  task automatic m_reset();
    for (int p = 0; p < 2; p++) begin
      m_h[p] = MAXH; m_l[p] = MAXL; m_dead[p] = 0; m_inv[p] = 0;
      m_resp[p] = 0; m_alive[p] = 1;
    end
    m_over = 0; m_win = 0;
  endtask

  task automatic m_step(bit h1, bit h2, bit f1, bit f2, bit tk, bit rs);
    bit hit[2], fall[2], nout[2];
    hit[0] = h1; hit[1] = h2; fall[0] = f1; fall[1] = f2;
    m_resp[0] = 0; m_resp[1] = 0;
    if (m_over) begin
      if (rs) begin
        m_reset();
        m_resp[0] = 1; m_resp[1] = 1;
      end
      return;
    end
    for (int p = 0; p < 2; p++) begin
      nout[p] = 0;
      if (m_l[p] == 0) continue;
      if (m_dead[p] > 0) begin
        if (tk) begin
          m_dead[p]--;
          if (m_dead[p] == 0) begin
            m_h[p] = MAXH; m_alive[p] = 1; m_resp[p] = 1;
            m_inv[p] = INV_EN ? INV : 0;
          end
        end
      end else if (fall[p] || (hit[p] && m_inv[p] == 0 && m_h[p] <= 1)) begin
        m_h[p] = 0; m_l[p]--; m_alive[p] = 0; m_inv[p] = 0;
        if (m_l[p] == 0) nout[p] = 1;
        else m_dead[p] = RESP;
      end else if (hit[p] && m_inv[p] == 0) begin
        m_h[p]--;
        m_inv[p] = INV_EN ? INV : 0;
      end else if (tk && m_inv[p] > 0) begin
        m_inv[p]--;
      end
    end
    if (nout[0] || nout[1]) begin
      m_over = 1;
      m_win = (nout[0] && nout[1]) ? 3 : (nout[0] ? 2 : 1);
    end
  endtask

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic chk_model(string tag);
    chk({tag, " h1"}, Player1Health, m_h[0]);
    chk({tag, " h2"}, Player2Health, m_h[1]);
    chk({tag, " l1"}, Player1Lives, m_l[0]);
    chk({tag, " l2"}, Player2Lives, m_l[1]);
    chk({tag, " win"}, winner, m_win);
    chk({tag, " resp1"}, respawn1, m_resp[0]);
    chk({tag, " resp2"}, respawn2, m_resp[1]);
    chk({tag, " alive1"}, alive1, m_alive[0]);
    chk({tag, " alive2"}, alive2, m_alive[1]);
  endtask

  task automatic cyc(bit h1, bit h2, bit f1, bit f2, bit tk, bit rs);
    hit1 = h1; hit2 = h2; fall1 = f1; fall2 = f2; frame_tick = tk; restart = rs;
    @(posedge Clk); #1;
    hit1 = 0; hit2 = 0; fall1 = 0; fall2 = 0; frame_tick = 0; restart = 0;
    m_step(h1, h2, f1, f2, tk, rs);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1, 0);
  endtask

  task automatic do_reset();
    #2 Reset = 1'b1;
    #1 m_reset();
    @(posedge Clk); #1 Reset = 1'b0;
  endtask

  typedef struct {
    bit h1, h2, f1, f2, tk, rs;
    int eh1, eh2, el1, el2, ew;
    bit ea1, ea2;
  } vec_t;

  localparam int H1C = INV_EN ? 4 : 3;
  vec_t tbl[8];

  initial begin
    int c1, c2, idx, hs, as;
    tbl[0] = '{1,0,0,0,0,0, 4,   5, 3, 3, 0, 1, 1};
    tbl[1] = '{0,1,0,0,1,0, 4,   4, 3, 3, 0, 1, 1};
    tbl[2] = '{1,0,0,0,0,0, H1C, 4, 3, 3, 0, 1, 1};
    tbl[3] = '{0,0,0,0,1,1, H1C, 4, 3, 3, 0, 1, 1};
    tbl[4] = '{0,0,0,1,0,0, H1C, 0, 3, 2, 0, 1, 0};
    tbl[5] = '{0,1,0,0,1,0, H1C, 0, 3, 2, 0, 1, 0};
    tbl[6] = '{1,0,1,0,0,0, 0,   0, 2, 2, 0, 0, 0};
    tbl[7] = '{1,0,0,0,0,0, 0,   0, 2, 2, 0, 0, 0};

    // reset state
    m_reset();
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    chk_model("reset");
    chk("reset h1 const", Player1Health, MAXH);
    chk("reset l2 const", Player2Lives, MAXL);

    // vector table
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].h1, tbl[i].h2, tbl[i].f1, tbl[i].f2, tbl[i].tk, tbl[i].rs);
      chk($sformatf("tbl%0d h1", i), Player1Health, tbl[i].eh1);
      chk($sformatf("tbl%0d h2", i), Player2Health, tbl[i].eh2);
      chk($sformatf("tbl%0d l1", i), Player1Lives, tbl[i].el1);
      chk($sformatf("tbl%0d l2", i), Player2Lives, tbl[i].el2);
      chk($sformatf("tbl%0d win", i), winner, tbl[i].ew);
      chk($sformatf("tbl%0d a1", i), alive1, tbl[i].ea1);
      chk($sformatf("tbl%0d a2", i), alive2, tbl[i].ea2);
    end

    // four hits one frame apart
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 0, 0, 0, 0);
      if (k < 3) ticks(1);
    end
    chk("burst h1", Player1Health, INV_EN ? 4 : 1);

    // five spaced hits, death with a coincident tick, exact respawn latency
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 0, 0, 0, 0);
      ticks(32);
    end
    chk("spaced h1", Player1Health, 1);
    cyc(1, 0, 0, 0, 1, 0);
    chk("death l1", Player1Lives, 2);
    chk("death a1", alive1, 0);
    chk("death h1", Player1Health, 0);
    c1 = 0; idx = -1; hs = -1; as = -1;
    for (int t = 1; t <= RESP + 5; t++) begin
      cyc(0, 0, 0, 0, 1, 0);
      if (respawn1) begin
        c1++;
        if (idx < 0) begin idx = t; hs = Player1Health; as = alive1; end
      end
    end
    chk("respawn count", c1, 1);
    chk("respawn tick", idx, RESP);
    chk("respawn h1", hs, MAXH);
    chk("respawn a1", as, 1);

    // P2 falls out three times; frozen OVER; restart
    do_reset();
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 0, 1, 0, 0);
      ticks(RESP);
    end
    chk("fall l2", Player2Lives, 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("out l2", Player2Lives, 0);
    chk("out win", winner, 1);
    chk("out a2", alive2, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(0, 1, 1, 1, 1, 0);
    ticks(RESP + 2);
    chk("frozen h1", Player1Health, MAXH);
    chk("frozen l1", Player1Lives, MAXL);
    chk("frozen l2", Player2Lives, 0);
    chk("frozen win", winner, 1);
    c1 = 0; c2 = 0;
    cyc(0, 0, 0, 0, 0, 1);
    if (respawn1) c1++;
    if (respawn2) c2++;
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      if (respawn1) c1++;
      if (respawn2) c2++;
    end
    chk("restart resp1", c1, 1);
    chk("restart resp2", c2, 1);
    chk("restart h2", Player2Health, MAXH);
    chk("restart l2", Player2Lives, MAXL);
    chk("restart win", winner, 0);
    chk("restart a2", alive2, 1);

    // simultaneous final deaths give a draw
    do_reset();
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 1, 1, 0, 0);
      ticks(RESP);
    end
    ticks(32);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, 0, 0, 0, 0);
      ticks(32);
    end
    chk("draw pre h1", Player1Health, 1);
    chk("draw pre h2", Player2Health, 1);
    chk("draw pre l1", Player1Lives, 1);
    cyc(1, 1, 0, 0, 0, 0);
    chk("draw win", winner, 3);
    chk("draw l1", Player1Lives, 0);
    chk("draw l2", Player2Lives, 0);

    // asynchronous reset 20 ticks into DEAD
    do_reset();
    cyc(0, 0, 1, 0, 0, 0);
    ticks(20);
    chk("dead a1", alive1, 0);
    #2 Reset = 1'b1;
    #1;
    chk("areset h1", Player1Health, MAXH);
    chk("areset l1", Player1Lives, MAXL);
    chk("areset a1", alive1, 1);
    chk("areset resp1", respawn1, 0);
    m_reset();
    @(posedge Clk); #1 Reset = 1'b0;
    c1 = 0;
    chk("release resp1", respawn1, 0);
    for (int t = 0; t < RESP + 5; t++) begin
      cyc(0, 0, 0, 0, 1, 0);
      if (respawn1) c1++;
    end
    chk("post reset respawns", c1, 0);

    // randomized events against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bit h1, h2, f1, f2, tk, rs;
      h1 = ($urandom_range(5) == 0);
      h2 = ($urandom_range(5) == 0);
      f1 = ($urandom_range(47) == 0);
      f2 = ($urandom_range(47) == 0);
      tk = ($urandom_range(1) == 0);
      rs = ($urandom_range(15) == 0);
      cyc(h1, h2, f1, f2, tk, rs);
      chk_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
